// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants for dm_port_arbiter: FSM state encodings, legal byte-enable
// patterns and the alignment check used when DM_ADDR_CHECK_EN is defined.
package dm_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Legal = a byte/half/word shape whose lowest lane matches the byte offset.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic       shape_ok;
    logic [1:0] low_lane;
    shape_ok = (be == BE_BYTE0) || (be == BE_BYTE1) || (be == BE_BYTE2) ||
               (be == BE_BYTE3) || (be == BE_HALF0) || (be == BE_HALF1) ||
               (be == BE_WORD);
    if (be[0])      low_lane = 2'd0;
    else if (be[1]) low_lane = 2'd1;
    else if (be[2]) low_lane = 2'd2;
    else            low_lane = 2'd3;
    return shape_ok && (low_lane == addr_lo);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant flop updated on advance.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last_grant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (advance && (|req)) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin sharing of the single-port data memory between the CPU (m0) and a
// debug/DMA loader (m1). Define DM_ADDR_CHECK_EN to reject misaligned/illegal BE.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_be,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_be,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

  logic [1:0]        r_state;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-3:0] r_waddr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_grant;
  logic              w_advance;
  logic              w_bad;
  logic              w_issue;
  logic              w_resp;
  logic              w_rsp_err;
  logic [DATA_W-1:0] w_rdata;

  assign w_advance = (r_state == ARB_IDLE) && (m0_req || m1_req);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .advance (w_advance),
    .grant   (w_grant)
  );

`ifdef DM_ADDR_CHECK_EN
  logic [1:0] r_alo;
  logic       r_err;

  assign w_bad     = (r_state == ARB_ISSUE) && !be_legal(r_be, r_alo);
  assign w_rsp_err = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alo <= '0;
      r_err <= 1'b0;
    end else if (w_advance) begin
      r_alo <= w_grant[1] ? m1_addr[1:0] : m0_addr[1:0];
    end else if (r_state == ARB_ISSUE) begin
      r_err <= w_bad;
    end
  end
`else
  assign w_bad     = 1'b0;
  assign w_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_advance) begin
            r_port  <= w_grant[1];
            r_we    <= w_grant[1] ? m1_we    : m0_we;
            r_waddr <= w_grant[1] ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
            r_be    <= w_grant[1] ? m1_be    : m0_be;
            r_wdata <= w_grant[1] ? m1_wdata : m0_wdata;
            r_state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // WAIT holds MEM_LAT-1 cycles, so the counter starts at MEM_LAT-2.
          if (w_bad || (MEM_LAT == 1)) begin
            r_state <= ARB_RESP;
          end else begin
            r_cnt   <= CNT_W'(MEM_LAT - 2);
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ARB_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign w_issue   = (r_state == ARB_ISSUE) && !w_bad;
  assign mem_en    = w_issue;
  assign mem_we    = (w_issue && r_we) ? r_be : 4'b0000;
  assign mem_addr  = r_waddr;
  assign mem_wdata = r_wdata;

  assign w_resp  = (r_state == ARB_RESP);
  assign w_rdata = (w_resp && !r_we && !w_rsp_err) ? mem_rdata : '0;

  assign m0_ack   = w_resp && !r_port;
  assign m1_ack   = w_resp && r_port;
  assign m0_rdata = m0_ack ? w_rdata : '0;
  assign m1_rdata = m1_ack ? w_rdata : '0;
  assign m0_err   = m0_ack && w_rsp_err;
  assign m1_err   = m1_ack && w_rsp_err;

  assign busy = (r_state != ARB_IDLE);

endmodule
